// File: rtl/e_adder_pkg.sv
// Shared types for the pipelined adder.
//   mode_e     : operation code carried by every token (ADD/SUB/ACC/CLR).
//   tok_ctrl_t : control part of a pipeline token (valid, mode, carry into
//                the next segment).
// The full token (control plus partial sum and the operand bits still to be
// added) depends on WIDTH, so e_pipe_adder wraps tok_ctrl_t together with
// WIDTH-sized data fields in its own token typedef.
package e_adder_pkg;

    typedef enum logic [1:0] {
        MODE_ADD = 2'd0,
        MODE_SUB = 2'd1,
        MODE_ACC = 2'd2,
        MODE_CLR = 2'd3
    } mode_e;

    typedef struct packed {
        logic  valid;
        mode_e mode;
        logic  carry;
    } tok_ctrl_t;

    // ACC and CLR both write the accumulator and both lock the input
    // until they reach the output register.
    function automatic logic is_acc_op(input mode_e m);
        return (m == MODE_ACC) || (m == MODE_CLR);
    endfunction

endpackage

// File: rtl/e_pipe_adder_seg.sv
// e_add_seg: one combinational ripple-carry segment of SEG_W bits.
// Ports:
//   a, b     : segment operand bits
//   cin      : carry into the segment LSB
//   s        : segment sum bits
//   cout     : carry out of the segment MSB
//   msb_cin  : carry into the segment MSB (XOR with cout gives signed
//              overflow when this is the top segment)
module e_add_seg #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] s,
    output logic             cout,
    output logic             msb_cin
);

    // The carry is rippled through a block-local variable so the chain is
    // a single combinational process rather than a self-referencing vector.
    always_comb begin
        logic carry;
        carry   = cin;
        msb_cin = cin;
        s       = '0;
        for (int i = 0; i < SEG_W; i++) begin
            if (i == SEG_W - 1) begin
                msb_cin = carry;
            end
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/e_pipe_adder.sv
// e_pipe_adder: valid/ready pipelined adder/subtractor/accumulator.
// The WIDTH-bit addition is cut into STAGES segments; segment k is added in
// pipeline stage k using the carry registered by stage k-1.  Stage 0 is
// computed straight from the accepted inputs, stages 1..STAGES-2 are token
// registers and the last stage feeds the output register, so a result
// appears STAGES cycles after acceptance.
// Ports:
//   clk, rst            : clock (rising edge), async active-high reset
//   in_valid / in_ready : input handshake
//   mode                : 0 ADD a+b+cin, 1 SUB a-b, 2 ACC acc+a+cin, 3 CLR
//   a, b, cin           : operands (b unused for ACC/CLR, cin unused SUB/CLR)
//   out_valid/out_ready : output handshake
//   sum, cout, ovf      : result, carry-out (SUB: 1 = no borrow), overflow
module e_pipe_adder
    import e_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG_W = WIDTH / STAGES;

    generate
        if ((WIDTH % STAGES) != 0 || STAGES < 2) begin : g_bad_params
            $error("e_pipe_adder: WIDTH must be a multiple of STAGES and STAGES >= 2");
        end
    endgenerate

    // Token: control, partial sum (low segments already added) and the
    // effective operands whose upper segments are still to be added.
    typedef struct packed {
        tok_ctrl_t        ctrl;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
    } tok_t;

    mode_e            in_mode;
    logic             stall;
    logic             accept;
    logic             acc_busy_reg;
    logic [WIDTH-1:0] acc_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             cout_reg;
    logic             ovf_reg;

    tok_t             in_tok;
    tok_t             tok_reg [STAGES-1];
    tok_t             src_tok [STAGES];
    logic [STAGES-1:0] en;

    logic [SEG_W-1:0] seg_s  [STAGES];
    logic             seg_co [STAGES];
    logic             seg_mc [STAGES];

    assign in_mode  = mode_e'(mode);
    assign stall    = out_valid_reg && !out_ready;
    assign in_ready = !rst && !acc_busy_reg && !stall;
    assign accept   = in_valid && in_ready;

    // Map every mode onto a plain a + b + c addition.  CLR adds zeros, which
    // makes sum, cout and ovf all come out 0 with no special casing.
    always_comb begin
        in_tok            = '0;
        in_tok.ctrl.valid = accept;
        in_tok.ctrl.mode  = in_mode;
        in_tok.ctrl.carry = cin;
        in_tok.op_a       = a;
        in_tok.op_b       = b;
        case (in_mode)
            MODE_SUB: begin
                in_tok.op_b       = ~b;
                in_tok.ctrl.carry = 1'b1;
            end
            MODE_ACC: begin
                in_tok.op_a = acc_reg;
                in_tok.op_b = a;
            end
            MODE_CLR: begin
                in_tok.op_a       = '0;
                in_tok.op_b       = '0;
                in_tok.ctrl.carry = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // A stage may load when it is empty or its content moves on, so bubbles
    // are squeezed out even while the output is stalled.
    always_comb begin
        en             = '0;
        en[STAGES-1]   = !out_valid_reg || out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            en[k] = !tok_reg[k].ctrl.valid || en[k+1];
        end
    end

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_src_in
                assign src_tok[gi] = in_tok;
            end else begin : g_src_reg
                assign src_tok[gi] = tok_reg[gi-1];
            end

            e_add_seg #(
                .SEG_W(SEG_W)
            ) u_seg (
                .a       (src_tok[gi].op_a[gi*SEG_W +: SEG_W]),
                .b       (src_tok[gi].op_b[gi*SEG_W +: SEG_W]),
                .cin     (src_tok[gi].ctrl.carry),
                .s       (seg_s[gi]),
                .cout    (seg_co[gi]),
                .msb_cin (seg_mc[gi])
            );

            if (gi < STAGES - 1) begin : g_mid
                tok_t nxt;

                always_comb begin
                    nxt                           = src_tok[gi];
                    nxt.ctrl.carry                = seg_co[gi];
                    nxt.sum[gi*SEG_W +: SEG_W]    = seg_s[gi];
                end

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        tok_reg[gi] <= '0;
                    end else if (en[gi]) begin
                        tok_reg[gi] <= nxt;
                    end
                end
            end
        end
    endgenerate

    // Final segment result as it enters the output register.
    logic [WIDTH-1:0] fin_sum;
    logic             fin_valid;
    mode_e            fin_mode;
    logic             fin_load;

    always_comb begin
        fin_sum = src_tok[STAGES-1].sum;
        fin_sum[(STAGES-1)*SEG_W +: SEG_W] = seg_s[STAGES-1];
    end

    assign fin_valid = src_tok[STAGES-1].ctrl.valid;
    assign fin_mode  = src_tok[STAGES-1].ctrl.mode;
    assign fin_load  = en[STAGES-1] && fin_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            sum_reg       <= '0;
            cout_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else if (en[STAGES-1]) begin
            out_valid_reg <= fin_valid;
            if (fin_valid) begin
                sum_reg  <= fin_sum;
                cout_reg <= seg_co[STAGES-1];
                ovf_reg  <= seg_co[STAGES-1] ^ seg_mc[STAGES-1];
            end
        end
    end

    // The accumulator is written as its token enters the output register;
    // acc_busy keeps the input closed until then, so the next ACC read in
    // stage 0 always sees the latest value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg      <= '0;
            acc_busy_reg <= 1'b0;
        end else begin
            if (fin_load && is_acc_op(fin_mode)) begin
                acc_reg      <= (fin_mode == MODE_ACC) ? fin_sum : '0;
                acc_busy_reg <= 1'b0;
            end
            if (accept && is_acc_op(in_mode)) begin
                acc_busy_reg <= 1'b1;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;

endmodule
